// File: rtl/store_narrow_rmw_if.sv
// Bus bundle for the store narrowing unit: request side from the core and
// read/write side toward a data memory without byte enables.
interface store_narrow_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              check_range;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              trunc_ovf;
  logic              err;

  modport master (
    output req_valid, req_addr, req_data, req_size, check_range, mem_rdata, mem_rvalid,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, trunc_ovf, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, check_range, mem_rdata, mem_rvalid,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, trunc_ovf, err
  );
endinterface

// File: rtl/store_narrow_rmw.sv
// Store-side narrowing unit: sb/sh become read-modify-write cycles on a word
// memory, sw is written directly; optional signed range check on the narrowed value.
module store_narrow_rmw #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  store_narrow_rmw_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;
  logic [1:0]        size_r;
  logic              chk_r;
  logic [31:0]       rdata_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              ready_r, rd_en_r, wr_en_r, done_r, ovf_r, err_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;

  logic              accept_s, bad_req_s, wait_expired_s;
  logic [ADDR_W-1:0] eff_addr_s;
  logic [31:0]       eff_data_s, eff_rdata_s;
  logic [1:0]        eff_size_s, lane_s;
  logic              eff_chk_s;
  logic              ready_s, rd_en_s, wr_en_s, ovf_s, err_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_wdata_s;

  // Replace the addressed lane(s) of the old word; lane[1] also picks the half.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] wr_data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: res[{lane, 3'b000} +: 8] = wr_data[7:0];
      2'b01: begin
        if (lane[1]) res[31:16] = wr_data[15:0];
        else         res[15:0]  = wr_data[15:0];
      end
      2'b10:   res = wr_data;
      default: res = old_word;
    endcase
    return res;
  endfunction

  function automatic logic range_ovf(input logic [31:0] wr_data, input logic [1:0] size);
    logic ovf;
    case (size)
      2'b00:   ovf = (wr_data[31:8]  != {24{wr_data[7]}});
      2'b01:   ovf = (wr_data[31:16] != {16{wr_data[15]}});
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

  assign accept_s  = bus.req_valid & ready_r;
  assign bad_req_s = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  assign wait_expired_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Outputs are registered from the next state, so the request and read data
  // must be taken live on the cycle they are being latched.
  assign eff_addr_s  = (state_r == ST_IDLE) ? bus.req_addr    : addr_r;
  assign eff_data_s  = (state_r == ST_IDLE) ? bus.req_data    : data_r;
  assign eff_size_s  = (state_r == ST_IDLE) ? bus.req_size    : size_r;
  assign eff_chk_s   = (state_r == ST_IDLE) ? bus.check_range : chk_r;
  assign eff_rdata_s = (state_r == ST_WAIT) ? bus.mem_rdata   : rdata_r;
  assign lane_s      = (BIG_ENDIAN != 0) ? ~eff_addr_s[1:0] : eff_addr_s[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s)                  state_next_s = ST_IDLE;
        else if (bad_req_s)             state_next_s = ST_ERR;
        else if (bus.req_size == 2'b10) state_next_s = ST_WR;
        else                            state_next_s = ST_RD;
      end
      ST_RD: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.mem_rvalid)      state_next_s = ST_WR;
        else if (wait_expired_s) state_next_s = ST_ERR;
        else                     state_next_s = ST_WAIT;
      end
      ST_WR:   state_next_s = ST_IDLE;
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ready_s     = (state_next_s == ST_IDLE);
    rd_en_s     = (state_next_s == ST_RD);
    wr_en_s     = (state_next_s == ST_WR);
    err_s       = (state_next_s == ST_ERR);
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    ovf_s       = 1'b0;
    if (rd_en_s | wr_en_s) mem_addr_s = {eff_addr_s[ADDR_W-1:2], 2'b00};
    else                   mem_addr_s = mem_addr_r;
    if (wr_en_s) begin
      mem_wdata_s = merge_lane(eff_rdata_s, eff_data_s, eff_size_s, lane_s);
      ovf_s       = eff_chk_s & range_ovf(eff_data_s, eff_size_s);
    end else begin
      mem_wdata_s = mem_wdata_r;
      ovf_s       = 1'b0;
    end
  end

  // Request latch, read-data capture and read timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= 32'h0;
      size_r  <= 2'b00;
      chk_r   <= 1'b0;
      rdata_r <= 32'h0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r <= bus.req_addr;
        data_r <= bus.req_data;
        size_r <= bus.req_size;
        chk_r  <= bus.check_range;
      end
      if (state_r == ST_RD) cnt_r <= {CNT_W{1'b0}};
      else if ((state_r == ST_WAIT) && !bus.mem_rvalid) cnt_r <= cnt_r + CNT_W'(1);
      if ((state_r == ST_WAIT) && bus.mem_rvalid) rdata_r <= bus.mem_rdata;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b1;
      rd_en_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'h0;
    end else begin
      ready_r     <= ready_s;
      rd_en_r     <= rd_en_s;
      wr_en_r     <= wr_en_s;
      done_r      <= wr_en_s;
      ovf_r       <= ovf_s;
      err_r       <= err_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.mem_rd_en = rd_en_r;
  assign bus.mem_wr_en = wr_en_r;
  assign bus.done      = done_r;
  assign bus.trunc_ovf = ovf_r;
  assign bus.err       = err_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw: a little-endian and a big-endian
// instance receive identical stimulus; write data of both is checked.
module tb_store_narrow_rmw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        check_range = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;

  store_narrow_rmw_if #(.ADDR_W(32)) bus_le ();
  store_narrow_rmw_if #(.ADDR_W(32)) bus_be ();

  assign bus_le.req_valid   = req_valid;
  assign bus_le.req_addr    = req_addr;
  assign bus_le.req_data    = req_data;
  assign bus_le.req_size    = req_size;
  assign bus_le.check_range = check_range;
  assign bus_le.mem_rdata   = mem_rdata;
  assign bus_le.mem_rvalid  = mem_rvalid;
  assign bus_be.req_valid   = req_valid;
  assign bus_be.req_addr    = req_addr;
  assign bus_be.req_data    = req_data;
  assign bus_be.req_size    = req_size;
  assign bus_be.check_range = check_range;
  assign bus_be.mem_rdata   = mem_rdata;
  assign bus_be.mem_rvalid  = mem_rvalid;

  store_narrow_rmw #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst_n(rst_n), .bus(bus_le.slave)
  );
  store_narrow_rmw #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst_n(rst_n), .bus(bus_be.slave)
  );

  int errors = 0;
  int checks = 0;

  int          rd_cyc, wr_cyc, err_cyc, rd_cnt, wr_cnt;
  logic [31:0] rd_addr, wr_addr, wdata_le, wdata_be;
  logic        ovf, done_at_wr, ready_after;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one store; cycles counted from the accept edge (cycle 1 = N+1).
  // rv_delay < 0 withholds mem_rvalid entirely.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input logic chk,
                           input logic [31:0] rdata, input int rv_delay);
    int rv_cycle;
    bit fin;
    rv_cycle = -1; fin = 1'b0;
    rd_cyc = -1; wr_cyc = -1; err_cyc = -1; rd_cnt = 0; wr_cnt = 0;
    rd_addr = 32'hx; wr_addr = 32'hx; wdata_le = 32'hx; wdata_be = 32'hx;
    ovf = 1'bx; done_at_wr = 1'bx; ready_after = 1'bx;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
    check_range = chk; mem_rdata = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && !fin; k++) begin
      mem_rvalid = (k == rv_cycle);
      @(negedge clk);
      if (bus_le.mem_rd_en) begin
        rd_cnt++; rd_cyc = k; rd_addr = bus_le.mem_addr;
        if (rv_delay >= 0) rv_cycle = k + 1 + rv_delay;
      end
      if (bus_le.mem_wr_en) begin
        wr_cnt++; wr_cyc = k; wr_addr = bus_le.mem_addr;
        wdata_le = bus_le.mem_wdata; wdata_be = bus_be.mem_wdata;
        ovf = bus_le.trunc_ovf; done_at_wr = bus_le.done; fin = 1'b1;
      end
      if (bus_le.err) begin
        err_cyc = k; fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    ready_after = bus_le.req_ready;
  endtask

  initial begin
    int wr_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(bus_le.req_ready), 32'd1);
    check_val("rst_strobes", {27'd0, bus_le.mem_rd_en, bus_le.mem_wr_en, bus_le.done,
                              bus_le.trunc_ovf, bus_le.err}, 32'd0);
    check_val("rst_addr", bus_le.mem_addr, 32'h0);
    check_val("rst_wdata", bus_le.mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // sb -27 at addr 1
    run_store(32'h1, 32'hFFFFFFE5, 2'b00, 1'b1, 32'h11223344, 0);
    check_val("sb_rd_cyc", rd_cyc, 32'd1);
    check_val("sb_rd_addr", rd_addr, 32'h0);
    check_val("sb_wr_cyc", wr_cyc, 32'd3);
    check_val("sb_wdata", wdata_le, 32'h1122E544);
    check_val("sb_wdata_be", wdata_be, 32'h11E53344);
    check_val("sb_ovf", 32'(ovf), 32'd0);
    check_val("sb_done", 32'(done_at_wr), 32'd1);
    check_val("sb_ready", 32'(ready_after), 32'd1);

    // sh 999 at addr 2
    run_store(32'h2, 32'h000003E7, 2'b01, 1'b1, 32'hAABBCCDD, 0);
    check_val("sh_wdata", wdata_le, 32'h03E7CCDD);
    check_val("sh_wdata_be", wdata_be, 32'hAABB03E7);
    check_val("sh_ovf", 32'(ovf), 32'd0);

    // sb 999 at addr 0 overflows a byte
    run_store(32'h0, 32'h000003E7, 2'b00, 1'b1, 32'hAABBCCDD, 0);
    check_val("sb0_wdata", wdata_le, 32'hAABBCCE7);
    check_val("sb0_wdata_be", wdata_be, 32'hE7BBCCDD);
    check_val("sb0_ovf", 32'(ovf), 32'd1);

    // sw -786 at addr 4
    run_store(32'h4, 32'hFFFFFCEE, 2'b10, 1'b1, 32'h0, 0);
    check_val("sw_rd_cnt", rd_cnt, 32'd0);
    check_val("sw_wr_cyc", wr_cyc, 32'd1);
    check_val("sw_addr", wr_addr, 32'h4);
    check_val("sw_wdata", wdata_le, 32'hFFFFFCEE);
    check_val("sw_ovf", 32'(ovf), 32'd0);

    // Misaligned half, illegal size, misaligned word
    run_store(32'h1, 32'd44, 2'b01, 1'b0, 32'h0, 0);
    check_val("sh_mis_err", err_cyc, 32'd1);
    check_val("sh_mis_rw", rd_cnt + wr_cnt, 32'd0);
    check_val("sh_mis_ready", 32'(ready_after), 32'd1);
    run_store(32'h0, 32'd44, 2'b11, 1'b0, 32'h0, 0);
    check_val("ill_err", err_cyc, 32'd1);
    check_val("ill_rw", rd_cnt + wr_cnt, 32'd0);
    check_val("ill_ready", 32'(ready_after), 32'd1);
    run_store(32'h2, 32'd44, 2'b10, 1'b0, 32'h0, 0);
    check_val("sw_mis_err", err_cyc, 32'd1);

    // Read timeout: 15 WAIT cycles after the read strobe, then err
    run_store(32'h3, 32'h000000AB, 2'b00, 1'b0, 32'h11223344, -1);
    check_val("to_rd_cyc", rd_cyc, 32'd1);
    check_val("to_err_cyc", err_cyc, 32'd17);
    check_val("to_wr_cnt", wr_cnt, 32'd0);

    // rvalid on the last permitted WAIT cycle still writes
    run_store(32'h3, 32'h000000AB, 2'b00, 1'b0, 32'h11223344, 14);
    check_val("late_wr_cyc", wr_cyc, 32'd17);
    check_val("late_err", err_cyc, 32'hFFFFFFFF);
    check_val("late_wdata", wdata_le, 32'hAB223344);
    check_val("late_wdata_be", wdata_be, 32'h112233AB);

    // Delayed rvalid, out-of-range byte with check disabled
    run_store(32'h2, 32'h12345680, 2'b00, 1'b0, 32'h0, 3);
    check_val("dly_wr_cyc", wr_cyc, 32'd6);
    check_val("dly_wdata", wdata_le, 32'h00800000);
    check_val("dly_ovf", 32'(ovf), 32'd0);

    // Reset while waiting for read data
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h105; req_data = 32'h55; req_size = 2'b00;
    check_range = 1'b0; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_ready", 32'(bus_le.req_ready), 32'd1);
    check_val("mid_rst_addr", bus_le.mem_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1;
    wr_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_le.mem_wr_en || bus_le.done) wr_seen++;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    check_val("mid_rst_no_wr", wr_seen, 32'd0);
    run_store(32'h8, 32'h12345678, 2'b10, 1'b0, 32'h0, 0);
    check_val("post_rst_wr_cyc", wr_cyc, 32'd1);
    check_val("post_rst_wdata", wdata_le, 32'h12345678);
    check_val("post_rst_addr", wr_addr, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
